// File: rtl/pipe_reg_ctrl.sv
// pipe_reg_ctrl: valid/ready stage register with skid buffer, flush and saturating stall counter
module pipe_reg_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_main, r_skid, w_main_nxt, w_skid_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_in_ready, r_out_valid;
  logic              w_in_fire, w_out_fire, w_stall;
  assign w_in_fire  = in_valid_i & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready_i;
  assign w_stall    = r_out_valid & ~out_ready_i;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt != EMPTY);
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i)
      w_state_nxt = EMPTY;
    else if (r_state == EMPTY)
      w_state_nxt = w_in_fire ? BUSY : EMPTY;
    else if (r_state == BUSY)
      w_state_nxt = (w_in_fire && !w_out_fire) ? FULL :
                    (!w_in_fire && w_out_fire) ? EMPTY : BUSY;
    else
      w_state_nxt = w_out_fire ? BUSY : FULL;
  end
  // on flush the registers keep their contents; validity alone is dropped
  always_comb begin
    w_main_nxt = r_main;
    w_skid_nxt = r_skid;
    if (!flush_i) begin
      w_main_nxt = (w_in_fire && (r_state == EMPTY || (r_state == BUSY && w_out_fire))) ? in_data_i :
                   (r_state == FULL && w_out_fire) ? r_skid : r_main;
      w_skid_nxt = (r_state == BUSY && w_in_fire && !w_out_fire) ? in_data_i : r_skid;
    end
    w_cnt_nxt = (w_stall && r_cnt != {CNT_W{1'b1}}) ? r_cnt + 1'b1 : r_cnt;
  end
  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_main;
  assign occ_o       = r_state;
  assign stall_cnt_o = r_cnt;
endmodule

// File: tb/tb_pipe_reg_ctrl.sv
// tb_pipe_reg_ctrl: directed vectors with hand-computed expectations for pipe_reg_ctrl
module tb_pipe_reg_ctrl;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  logic              clk_i = 1'b0;
  logic              rst_ni, flush_i, in_valid_i, out_ready_i;
  logic              in_ready_o, out_valid_o;
  logic [DATA_W-1:0] in_data_i, out_data_o;
  logic [1:0]        occ_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  int n_vec = 0;
  int n_err = 0;
  pipe_reg_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .occ_o(occ_o), .stall_cnt_o(stall_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk_all(input string tag, input logic rdy, input logic vld,
                         input logic [31:0] dat, input logic [1:0] occ, input logic [3:0] cnt);
    chk({tag, ".in_ready"}, 64'(in_ready_o), 64'(rdy));
    chk({tag, ".out_valid"}, 64'(out_valid_o), 64'(vld));
    chk({tag, ".out_data"}, 64'(out_data_o), 64'(dat));
    chk({tag, ".occ"}, 64'(occ_o), 64'(occ));
    chk({tag, ".stall_cnt"}, 64'(stall_cnt_o), 64'(cnt));
  endtask
  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; in_data_i = '0;
    step(); step();
    chk_all("reset", 1'b0, 1'b0, 32'h0, 2'd0, 4'd0);
    rst_ni = 1'b1;
    step();
    chk_all("release", 1'b1, 1'b0, 32'h0, 2'd0, 4'd0);
    // single word
    in_valid_i = 1'b1; in_data_i = 32'hDEADBEEF; out_ready_i = 1'b1;
    step();
    chk_all("single", 1'b1, 1'b1, 32'hDEADBEEF, 2'd1, 4'd0);
    in_valid_i = 1'b0;
    step();
    chk("single_drain.occ", 64'(occ_o), 64'd0);
    chk("single_drain.out_valid", 64'(out_valid_o), 64'd0);
    // streaming
    for (int i = 1; i <= 8; i++) begin
      in_valid_i = 1'b1; in_data_i = 32'(i);
      step();
      chk_all($sformatf("stream%0d", i), 1'b1, 1'b1, 32'(i), 2'd1, 4'd0);
    end
    in_valid_i = 1'b0;
    step();
    chk_all("stream_end", 1'b1, 1'b0, 32'h8, 2'd0, 4'd0);
    // backpressure into skid
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'hA;
    step();
    chk_all("bp_a", 1'b1, 1'b1, 32'hA, 2'd1, 4'd0);
    in_data_i = 32'hB;
    step();
    chk_all("bp_b", 1'b0, 1'b1, 32'hA, 2'd2, 4'd1);
    in_valid_i = 1'b0;
    step();
    chk_all("bp_hold", 1'b0, 1'b1, 32'hA, 2'd2, 4'd2);
    out_ready_i = 1'b1;
    step();
    chk_all("bp_rel_b", 1'b1, 1'b1, 32'hB, 2'd1, 4'd2);
    step();
    chk_all("bp_empty", 1'b1, 1'b0, 32'hB, 2'd0, 4'd2);
    // flush while full, with a word offered in the flush cycle
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h11;
    step();
    in_data_i = 32'h22;
    step();
    chk_all("fl_full", 1'b0, 1'b1, 32'h11, 2'd2, 4'd3);
    flush_i = 1'b1; in_data_i = 32'h33;
    step();
    chk_all("fl_after", 1'b1, 1'b0, 32'h11, 2'd0, 4'd4);
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    step();
    chk_all("fl_idle", 1'b1, 1'b0, 32'h11, 2'd0, 4'd4);
    in_valid_i = 1'b1; in_data_i = 32'h44;
    step();
    chk_all("fl_next", 1'b1, 1'b1, 32'h44, 2'd1, 4'd4);
    in_valid_i = 1'b0;
    step();
    chk("fl_next_drain.occ", 64'(occ_o), 64'd0);
    // flush swallowing an accepted word from EMPTY
    flush_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'h77;
    step();
    chk_all("fl_swallow", 1'b1, 1'b0, 32'h44, 2'd0, 4'd4);
    flush_i = 1'b0; in_valid_i = 1'b0;
    step();
    chk("fl_swallow_idle.out_valid", 64'(out_valid_o), 64'd0);
    // reset while full
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h66;
    step();
    in_data_i = 32'h67;
    step();
    chk_all("rst_full", 1'b0, 1'b1, 32'h66, 2'd2, 4'd5);
    rst_ni = 1'b0; in_valid_i = 1'b0;
    step();
    chk_all("rst_mid", 1'b0, 1'b0, 32'h0, 2'd0, 4'd0);
    rst_ni = 1'b1;
    step();
    chk_all("rst_rel", 1'b1, 1'b0, 32'h0, 2'd0, 4'd0);
    in_valid_i = 1'b1; in_data_i = 32'h55; out_ready_i = 1'b1;
    step();
    chk_all("rst_55", 1'b1, 1'b1, 32'h55, 2'd1, 4'd0);
    in_valid_i = 1'b0;
    step();
    chk_all("rst_55_drain", 1'b1, 1'b0, 32'h55, 2'd0, 4'd0);
    // stall counter saturation with held output
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h99;
    step();
    in_valid_i = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("sat%0d.stall_cnt", i), 64'(stall_cnt_o), 64'(i > 15 ? 15 : i));
      chk($sformatf("sat%0d.out_data", i), 64'(out_data_o), 64'h99);
    end
    chk_all("sat_end", 1'b1, 1'b1, 32'h99, 2'd1, 4'd15);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
